uart_tx_frame_serializer: RTL

//  UART transmit serializer directly downstream of the Tx parity unit. Latches a byte and
//  the parity unit's ParityOut bit, then shifts the frame LSB-first onto the serial line:

---
 rtl/uart_tx_frame_serializer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_serializer.sv
// UART Tx serializer: start, LSB-first data, optional parity and 1/2 stop bits, one bit per BaudTick.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_frame_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  BaudTick,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [1:0]            ParityType,
    input  logic                  ParityBit,
    input  logic                  StopBits,
    output logic                  DataOut,
    output logic                  Busy,
    output logic                  Ready,
    output logic                  Done
);
    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_par_bit;
    logic                  r_par_en;
    logic                  r_stop2;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_load_frame;
    logic                  w_last_stop;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_par_bit;
    logic                  w_src_par_en;
    logic                  w_src_stop2;

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_par_bit;
    logic                  r_hold_par_en;
    logic                  r_hold_stop2;
    logic                  r_hold_valid;
    logic                  w_from_hold;

    assign Ready = ~r_hold_valid;
    assign Busy  = (r_state != S_IDLE) || r_hold_valid;

    assign w_src_data    = w_from_hold ? r_hold_data    : DataIn;
    assign w_src_par_bit = w_from_hold ? r_hold_par_bit : ParityBit;
    assign w_src_par_en  = w_from_hold ? r_hold_par_en  : ^ParityType;
    assign w_src_stop2   = w_from_hold ? r_hold_stop2   : StopBits;

    // An accept while idle goes straight into the frame registers; otherwise it is parked here.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_hold_data    <= '0;
            r_hold_par_bit <= 1'b0;
            r_hold_par_en  <= 1'b0;
            r_hold_stop2   <= 1'b0;
            r_hold_valid   <= 1'b0;
        end else if (w_accept && (r_state != S_IDLE)) begin
            r_hold_data    <= DataIn;
            r_hold_par_bit <= ParityBit;
            r_hold_par_en  <= ^ParityType;
            r_hold_stop2   <= StopBits;
            r_hold_valid   <= 1'b1;
        end else if (w_from_hold) begin
            r_hold_valid   <= 1'b0;
        end
    end
`else
    assign Ready = (r_state == S_IDLE);
    assign Busy  = (r_state != S_IDLE);

    assign w_src_data    = DataIn;
    assign w_src_par_bit = ParityBit;
    assign w_src_par_en  = ^ParityType;
    assign w_src_stop2   = StopBits;
`endif

    assign w_accept = Send && Ready;
    assign Done     = r_done;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_load_frame = 1'b0;
        w_last_stop  = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
        w_from_hold  = 1'b0;
`endif
        case (r_state)
            S_IDLE:   if (w_accept) begin
                          w_next_state = S_WAIT;
                          w_load_frame = 1'b1;
                      end
            S_WAIT:   if (BaudTick) w_next_state = S_START;
            S_START:  if (BaudTick) w_next_state = S_DATA;
            S_DATA:   if (BaudTick && (r_bit_cnt == LAST_BIT)) begin
                          w_next_state = r_par_en ? S_PARITY : S_STOP1;
                      end
            S_PARITY: if (BaudTick) w_next_state = S_STOP1;
            S_STOP1:  if (BaudTick) begin
                          if (r_stop2) begin
                              w_next_state = S_STOP2;
                          end else begin
                              w_next_state = S_IDLE;
                              w_last_stop  = 1'b1;
                          end
                      end
            S_STOP2:  if (BaudTick) begin
                          w_next_state = S_IDLE;
                          w_last_stop  = 1'b1;
                      end
            default:  w_next_state = S_IDLE;
        endcase
`ifdef UART_TX_HOLD_BUF_EN
        // A parked frame starts on the very tick that ends the current one, or leaves IDLE via WAIT.
        if (r_hold_valid && w_last_stop) begin
            w_next_state = S_START;
            w_load_frame = 1'b1;
            w_from_hold  = 1'b1;
        end else if (r_hold_valid && (r_state == S_IDLE)) begin
            w_next_state = S_WAIT;
            w_load_frame = 1'b1;
            w_from_hold  = 1'b1;
        end
`endif
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of order.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_bit <= 1'b0;
            r_par_en  <= 1'b0;
            r_stop2   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last_stop;
            if (w_load_frame) begin
                r_shift   <= w_src_data;
                r_par_bit <= w_src_par_bit;
                r_par_en  <= w_src_par_en;
                r_stop2   <= w_src_stop2;
                r_bit_cnt <= '0;
            end else if (BaudTick && (r_state == S_DATA)) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Line level is decoded from state, so an async reset returns the line to idle at once.
    always_comb begin
        DataOut = IDLE_LEVEL;
        case (r_state)
            S_START:  DataOut = ~IDLE_LEVEL;
            S_DATA:   DataOut = r_shift[0];
            S_PARITY: DataOut = r_par_bit;
            default:  DataOut = IDLE_LEVEL;
        endcase
    end

endmodule
